// File: rtl/iseq_receiver_mc_pkg.sv
// Shared opcode constants, FSM encodings and instruction helpers for the
// multi-lane instruction-sequence receiver.
package iseq_receiver_mc_pkg;

  // Opcode field position inside an instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;

  localparam logic [3:0] OPC_END = 4'hF;
  localparam logic [3:0] OPC_NOP = 4'h0;

  // ST_ISSUE names the issue step. It is folded into the cycle of the last
  // lane write, so the state register never actually holds it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV_APP,
    ST_RECV_MAINT,
    ST_PAD,
    ST_ISSUE
  } state_t;

  // Which instruction source owns the lane write path this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_APP,
    SRC_MAINT
  } src_t;

  // Builds an instruction word that carries only an opcode.
  function automatic logic [OPC_MSB:0] make_instr(input logic [3:0] opc);
    return {opc, {OPC_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/iseq_receiver_mc_lane_ptr.sv
// Round-robin lane pointer: counts 0..N_LANES-1, holds while stalled, and
// flags the last lane so the caller can tell when a row is complete.
module iseq_receiver_mc_lane_ptr #(
  parameter  int N_LANES = 2,
  localparam int PTR_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [PTR_W-1:0] ptr,
  output logic             last
);

  assign last = (ptr == PTR_W'(N_LANES - 1));

  // Advance one lane per unstalled cycle, wrapping after the last lane.
  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (!stall) begin
      ptr <= last ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/iseq_receiver_mc.sv
// Multi-lane instruction-sequence receiver. Accepts instructions from the
// app port or the maintenance handler, stripes them over N_LANES FIFOs,
// pads the final row with NOPs, and hands complete sequences to the
// dispatcher one at a time while buffering the next one.
module iseq_receiver_mc
  import iseq_receiver_mc_pkg::*;
#(
  parameter  int N_LANES      = 2,
  parameter  int INSTR_W      = 32,
  parameter  int MAX_ISEQ_LEN = 1024,
  localparam int LEN_W        = $clog2(MAX_ISEQ_LEN) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatcher_ready,
  input  logic                       app_en,
  output logic                       app_ack,
  input  logic [INSTR_W-1:0]         app_instr,
  input  logic                       maint_en,
  output logic                       maint_ack,
  input  logic [INSTR_W-1:0]         maint_instr,
  output logic [N_LANES-1:0]         lane_fifo_en,
  output logic [N_LANES*INSTR_W-1:0] lane_fifo_data,
  input  logic [N_LANES-1:0]         lane_fifo_full,
  output logic                       process_iseq,
  output logic [LEN_W-1:0]           iseq_len,
  output logic                       iseq_overflow
);

  localparam int                 PTR_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LEN_W-1:0]   LEN_LIMIT = LEN_W'(MAX_ISEQ_LEN - 1);
  localparam logic [INSTR_W-1:0] END_WORD  = INSTR_W'(make_instr(OPC_END));
  localparam logic [INSTR_W-1:0] NOP_WORD  = INSTR_W'(make_instr(OPC_NOP));

  state_t             state;
  src_t               src;
  logic               pending;
  logic [1:0]         guard;
  logic [LEN_W-1:0]   len;

  logic [PTR_W-1:0]   lane_ptr;
  logic               last_lane;
  logic               lane_full;
  logic               src_en;
  logic [INSTR_W-1:0] src_instr;
  logic               recv;
  logic               force_end;
  logic               wr_fire;
  logic [INSTR_W-1:0] wr_data;
  logic               app_take;
  logic               maint_take;
  logic               wr_end;
  logic               seq_done;
  logic               dispatch;

  iseq_receiver_mc_lane_ptr #(
    .N_LANES (N_LANES)
  ) u_lane_ptr (
    .clk   (clk),
    .rst   (rst),
    .stall (~wr_fire),
    .ptr   (lane_ptr),
    .last  (last_lane)
  );

  // Pick the source that owns the write path. A new sequence may start only
  // when nothing is buffered; maintenance wins only at a sequence boundary
  // and only while the dispatcher is idle.
  // NOTE: every signal assigned here gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    src = SRC_NONE;
    case (state)
      ST_IDLE: begin
        if (!pending) begin
          if (maint_en && dispatcher_ready) begin
            src = SRC_MAINT;
          end else if (app_en) begin
            src = SRC_APP;
          end
        end
      end
      ST_RECV_APP:   src = SRC_APP;
      ST_RECV_MAINT: src = SRC_MAINT;
      default:       src = SRC_NONE;
    endcase
  end

  assign src_en    = (src == SRC_APP)   ? app_en :
                     (src == SRC_MAINT) ? maint_en : 1'b0;
  assign src_instr = (src == SRC_MAINT) ? maint_instr : app_instr;
  assign lane_full = lane_fifo_full[lane_ptr];
  assign recv      = (state == ST_RECV_APP) || (state == ST_RECV_MAINT);
  // One slot short of the limit without an END: the next slot must be END.
  assign force_end = recv && (len == LEN_LIMIT);

  // Decide what, if anything, is written to the current lane this cycle.
  always_comb begin
    wr_fire    = 1'b0;
    wr_data    = src_instr;
    app_take   = 1'b0;
    maint_take = 1'b0;
    if (state == ST_PAD) begin
      wr_fire = !lane_full;
      wr_data = NOP_WORD;
    end else if (force_end) begin
      // The forced END is not acked, so the source keeps its instruction.
      wr_fire = !lane_full;
      wr_data = END_WORD;
    end else if ((src != SRC_NONE) && src_en && !lane_full) begin
      wr_fire    = 1'b1;
      app_take   = (src == SRC_APP);
      maint_take = (src == SRC_MAINT);
    end
  end

  assign wr_end   = wr_fire && (state != ST_PAD) &&
                    (wr_data[OPC_MSB:OPC_LSB] == OPC_END);
  // The sequence is complete once the END or a pad lands in the last lane.
  assign seq_done = wr_fire && last_lane && ((state == ST_PAD) || wr_end);
  assign dispatch = pending && dispatcher_ready && (guard == 2'd0);

  // Handshake and lane outputs are forced quiet while reset is held so a
  // reset mid-sequence cannot leak a write or ack from stale state.
  assign app_ack        = app_take & ~rst;
  assign maint_ack      = maint_take & ~rst;
  assign lane_fifo_en   = (wr_fire && !rst) ? (N_LANES'(1) << lane_ptr) : '0;
  assign lane_fifo_data = rst ? '0 : {N_LANES{wr_data}};

  // Receiver FSM with length counter, overflow flag, issue and dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pending       <= 1'b0;
      guard         <= 2'd0;
      len           <= '0;
      iseq_len      <= '0;
      iseq_overflow <= 1'b0;
      process_iseq  <= 1'b0;
    end else begin
      process_iseq <= dispatch;

      // The guard covers the cycles before the dispatcher's busy flag
      // makes it back to dispatcher_ready.
      if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
      if (dispatch) begin
        pending <= 1'b0;
        guard   <= 2'd2;
      end

      if (force_end && wr_fire) begin
        iseq_overflow <= 1'b1;
      end

      if (seq_done) begin
        // Issue step, taken in the same cycle as the final lane write.
        pending  <= 1'b1;
        iseq_len <= len + LEN_W'(1);
        len      <= '0;
        state    <= ST_IDLE;
      end else begin
        if (wr_fire) begin
          len <= len + LEN_W'(1);
        end
        case (state)
          ST_IDLE: begin
            if (wr_fire) begin
              if (wr_end) begin
                state <= ST_PAD;
              end else if (src == SRC_MAINT) begin
                state <= ST_RECV_MAINT;
              end else begin
                state <= ST_RECV_APP;
              end
            end
          end
          ST_RECV_APP, ST_RECV_MAINT: begin
            if (wr_end) begin
              state <= ST_PAD;
            end
          end
          ST_PAD:  state <= ST_PAD;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iseq_receiver_mc.sv
// Directed bench for iseq_receiver_mc. Instance a: 2 lanes, 8-entry
// sequences. Instance b: 4 lanes, default length. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_iseq_receiver_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatcher_ready;
  logic        app_en;
  logic [31:0] app_instr;
  logic        maint_en;
  logic [31:0] maint_instr;

  logic         a_app_ack, a_maint_ack, a_proc, a_ovf;
  logic [1:0]   a_en, a_full;
  logic [63:0]  a_data;
  logic [3:0]   a_len;

  logic         b_app_ack, b_maint_ack, b_proc, b_ovf;
  logic [3:0]   b_en, b_full;
  logic [127:0] b_data;
  logic [10:0]  b_len;

  logic focus_b;
  logic f_app_ack, f_maint_ack;

  int checks   = 0;
  int failures = 0;

  logic [34:0] log_a[$];
  logic [34:0] log_b[$];
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  iseq_receiver_mc #(.N_LANES(2), .INSTR_W(32), .MAX_ISEQ_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .app_en(app_en), .app_ack(a_app_ack), .app_instr(app_instr),
    .maint_en(maint_en), .maint_ack(a_maint_ack), .maint_instr(maint_instr),
    .lane_fifo_en(a_en), .lane_fifo_data(a_data), .lane_fifo_full(a_full),
    .process_iseq(a_proc), .iseq_len(a_len), .iseq_overflow(a_ovf)
  );

  iseq_receiver_mc #(.N_LANES(4), .INSTR_W(32), .MAX_ISEQ_LEN(1024)) dut_b (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .app_en(app_en), .app_ack(b_app_ack), .app_instr(app_instr),
    .maint_en(maint_en), .maint_ack(b_maint_ack), .maint_instr(maint_instr),
    .lane_fifo_en(b_en), .lane_fifo_data(b_data), .lane_fifo_full(b_full),
    .process_iseq(b_proc), .iseq_len(b_len), .iseq_overflow(b_ovf)
  );

  assign f_app_ack   = focus_b ? b_app_ack : a_app_ack;
  assign f_maint_ack = focus_b ? b_maint_ack : a_maint_ack;

  // Lane write log ({lane, word}) and dispatch pulse counters.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        if (a_en[i]) log_a.push_back({3'(i), a_data[i*32 +: 32]});
      for (int i = 0; i < 4; i++)
        if (b_en[i]) log_b.push_back({3'(i), b_data[i*32 +: 32]});
      if (a_proc) pulses_a++;
      if (b_proc) pulses_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int lane, input logic [31:0] d);
    return 64'({3'(lane), d});
  endfunction

  task automatic check_a(input string tag, input int idx, input int lane, input logic [31:0] d);
    check(tag, (idx < log_a.size()) ? 64'(log_a[idx]) : 64'hFFFF_FFFF_FFFF_FFFF, ent(lane, d));
  endtask

  task automatic check_b(input string tag, input int idx, input int lane, input logic [31:0] d);
    check(tag, (idx < log_b.size()) ? 64'(log_b[idx]) : 64'hFFFF_FFFF_FFFF_FFFF, ent(lane, d));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    app_en   = 1'b0;
    maint_en = 1'b0;
    a_full   = '0;
    b_full   = '0;
    cycles(2);
    rst = 1'b0;
  endtask

  // Offer one instruction on a source until the focused DUT acks it.
  task automatic send(input bit use_maint, input logic [31:0] instr, output bit other_acked);
    bit done = 1'b0;
    int n = 0;
    other_acked = 1'b0;
    if (use_maint) begin
      maint_en = 1'b1;
      maint_instr = instr;
    end else begin
      app_en = 1'b1;
      app_instr = instr;
    end
    while (!done && n < 40) begin
      @(negedge clk);
      done = use_maint ? f_maint_ack : f_app_ack;
      if (use_maint ? f_app_ack : f_maint_ack) other_acked = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    if (use_maint) maint_en = 1'b0;
    else app_en = 1'b0;
    if (use_maint) check("maint_accept", 64'(done), 64'd1);
    else check("app_accept", 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, p2, acks, k, n;
    bit o;

    // ---- reset state, with both sources requesting ----
    focus_b = 1'b0;
    rst = 1'b1;
    dispatcher_ready = 1'b1;
    app_en = 1'b1;
    app_instr = 32'h1000_0011;
    maint_en = 1'b1;
    maint_instr = 32'h4000_0001;
    a_full = '0;
    b_full = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_app_ack", 64'(a_app_ack), 64'd0);
    check("rst_maint_ack", 64'(a_maint_ack), 64'd0);
    check("rst_lane_en", 64'(a_en), 64'd0);
    check("rst_process", 64'(a_proc), 64'd0);
    check("rst_iseq_len", 64'(a_len), 64'd0);
    check("rst_overflow", 64'(a_ovf), 64'd0);
    check("rst_b_lane_en", 64'(b_en), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    app_en = 1'b0;
    maint_en = 1'b0;

    // ---- 2 lanes: ACT,RD,WR,END ----
    base = log_a.size();
    p = pulses_a;
    send(0, 32'h1000_0011, o);
    send(0, 32'h2000_0022, o);
    send(0, 32'h3000_0033, o);
    send(0, 32'hF000_0044, o);
    cycles(5);
    check("t1_writes", 64'(log_a.size() - base), 64'd4);
    check_a("t1_w0", base + 0, 0, 32'h1000_0011);
    check_a("t1_w1", base + 1, 1, 32'h2000_0022);
    check_a("t1_w2", base + 2, 0, 32'h3000_0033);
    check_a("t1_w3", base + 3, 1, 32'hF000_0044);
    check("t1_pulses", 64'(pulses_a - p), 64'd1);
    check("t1_iseq_len", 64'(a_len), 64'd4);

    // ---- 4 lanes: RD,END padded with two NOPs ----
    focus_b = 1'b1;
    do_reset();
    base = log_b.size();
    p = pulses_b;
    send(0, 32'h2000_0055, o);
    send(0, 32'hF000_0066, o);
    @(negedge clk);
    check("t2_no_early_pulse", 64'(pulses_b - p), 64'd0);
    cycles(6);
    check("t2_writes", 64'(log_b.size() - base), 64'd4);
    check_b("t2_w0", base + 0, 0, 32'h2000_0055);
    check_b("t2_w1", base + 1, 1, 32'hF000_0066);
    check_b("t2_w2", base + 2, 2, 32'h0000_0000);
    check_b("t2_w3", base + 3, 3, 32'h0000_0000);
    check("t2_iseq_len", 64'(b_len), 64'd4);
    check("t2_pulses", 64'(pulses_b - p), 64'd1);
    focus_b = 1'b0;

    // ---- maintenance priority over a waiting app request ----
    do_reset();
    dispatcher_ready = 1'b1;
    base = log_a.size();
    p = pulses_a;
    app_en = 1'b1;
    app_instr = 32'h1000_00A1;
    send(1, 32'h4000_00B1, o);
    check("t3_app_held_m1", 64'(o), 64'd0);
    send(1, 32'hF000_00B2, o);
    check("t3_app_held_mend", 64'(o), 64'd0);
    send(0, 32'h1000_00A1, o);
    cycles(1);
    check_a("t3_w0", base + 0, 0, 32'h4000_00B1);
    check_a("t3_w1", base + 1, 1, 32'hF000_00B2);
    check_a("t3_w2", base + 2, 0, 32'h1000_00A1);
    check("t3_pulses", 64'(pulses_a - p), 64'd1);

    // ---- buffering while the dispatcher is busy ----
    do_reset();
    dispatcher_ready = 1'b1;
    base = log_a.size();
    p = pulses_a;
    send(0, 32'h3000_0001, o);
    send(0, 32'hF000_0002, o);
    n = 0;
    while (pulses_a == p && n < 20) begin
      cycles(1);
      n++;
    end
    check("t4_first_pulse", 64'(pulses_a - p), 64'd1);
    dispatcher_ready = 1'b0;
    send(0, 32'h1000_0003, o);
    send(0, 32'hF000_0004, o);
    p2 = pulses_a;
    app_en = 1'b1;
    app_instr = 32'h2000_0005;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_app_ack) acks++;
      @(posedge clk);
      #1;
    end
    check("t4_third_held", 64'(acks), 64'd0);
    check("t4_no_pulse_busy", 64'(pulses_a - p2), 64'd0);
    check("t4_buffered_len", 64'(a_len), 64'd2);
    dispatcher_ready = 1'b1;
    send(0, 32'h2000_0005, o);
    cycles(3);
    check("t4_one_pulse", 64'(pulses_a - p2), 64'd1);
    check_a("t4_w4", base + 4, 0, 32'h2000_0005);

    // ---- lane 1 full for 5 cycles mid-sequence ----
    do_reset();
    dispatcher_ready = 1'b1;
    base = log_a.size();
    send(0, 32'h1000_0010, o);
    a_full = 2'b10;
    app_en = 1'b1;
    app_instr = 32'h2000_0020;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_app_ack) acks++;
      @(posedge clk);
      #1;
    end
    check("t5_stall_acks", 64'(acks), 64'd0);
    check("t5_stall_writes", 64'(log_a.size() - base), 64'd1);
    a_full = 2'b00;
    send(0, 32'h2000_0020, o);
    send(0, 32'hF000_0030, o);
    cycles(4);
    check_a("t5_w0", base + 0, 0, 32'h1000_0010);
    check_a("t5_w1", base + 1, 1, 32'h2000_0020);
    check_a("t5_w2", base + 2, 0, 32'hF000_0030);
    check_a("t5_w3", base + 3, 1, 32'h0000_0000);
    check("t5_iseq_len", 64'(a_len), 64'd4);

    // ---- overflow: no END within 8 slots ----
    do_reset();
    dispatcher_ready = 1'b0;
    base = log_a.size();
    p = pulses_a;
    app_en = 1'b1;
    k = 0;
    app_instr = 32'h5000_0000;
    repeat (20) begin
      @(negedge clk);
      if (a_app_ack) k++;
      @(posedge clk);
      #1;
      app_instr = 32'h5000_0000 + 32'(k);
    end
    check("t6_accepted", 64'(k), 64'd7);
    check("t6_overflow", 64'(a_ovf), 64'd1);
    check("t6_iseq_len", 64'(a_len), 64'd8);
    check("t6_writes", 64'(log_a.size() - base), 64'd8);
    check_a("t6_w6", base + 6, 0, 32'h5000_0006);
    check_a("t6_forced_end", base + 7, 1, 32'hF000_0000);
    check("t6_no_pulse_busy", 64'(pulses_a - p), 64'd0);
    dispatcher_ready = 1'b1;
    cycles(4);
    check("t6_pulse", 64'(pulses_a - p), 64'd1);
    check("t6_overflow_sticky", 64'(a_ovf), 64'd1);

    // ---- reset in the middle of the next sequence ----
    rst = 1'b1;
    cycles(1);
    @(negedge clk);
    check("t6_rst_app_ack", 64'(a_app_ack), 64'd0);
    check("t6_rst_lane_en", 64'(a_en), 64'd0);
    check("t6_rst_process", 64'(a_proc), 64'd0);
    check("t6_rst_iseq_len", 64'(a_len), 64'd0);
    check("t6_rst_overflow", 64'(a_ovf), 64'd0);
    @(posedge clk);
    #1;
    base = log_a.size();
    p = pulses_a;
    rst = 1'b0;
    app_en = 1'b0;
    cycles(8);
    check("t6_post_rst_pulses", 64'(pulses_a - p), 64'd0);
    check("t6_post_rst_writes", 64'(log_a.size() - base), 64'd0);
    check("t6_post_rst_overflow", 64'(a_ovf), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
